reset_sequencer: RTL and testbench

- Multi-channel reset sequencer.
- Takes one asynchronous system reset and one asynchronous "ready" qualifier (e.g. PLL/transceiver lock).
- Drives CHANNELS synchronous active-high resets in clk domain: asserted together, held a minimum time, then released one at a time in ascending channel order at fixed spacing.
- Sits at the clock/reset root of each SATA clock domain, replacing per-domain single-bit reset synchronizers.

---
 rtl/reset_sequencer_pkg.sv | 26 ++
 rtl/bit_synchronizer.sv | 28 ++
 rtl/reset_sequencer.sv | 174 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the multi-channel reset sequencer.
// The optional abort counter is enabled by defining RESET_SEQUENCER_ABORT_CNT_EN.
package reset_sequencer_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    HOLD       = 2'd0,
    WAIT_READY = 2'd1,
    RELEASE    = 2'd2,
    DONE       = 2'd3
  } state_t;

  // Saturation value of the optional abort counter.
  localparam logic [7:0] ABORT_CNT_MAX = 8'hff;

  // Width of the shared hold/step counter: wide enough to hold max(hold, step).
  function automatic int cnt_width(input int hold, input int step);
    int m;
    m = (hold > step) ? hold : step;
    if (m < 1) begin
      return 1;
    end
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level.
// The chain clears to 0 on the asynchronous reset.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the sampled level through the chain; the last stage is the clean output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer.
// All channels assert together on system reset, are held for HOLD_CYCLES, wait
// for the synchronized ready qualifier, then release one by one in ascending
// order every STEP_CYCLES. Losing ready or a sw_reset pulse restarts the
// sequence from the all-asserted hold.
// Optional: define RESET_SEQUENCER_ABORT_CNT_EN to add the abort_cnt output,
// a saturating count of ready-loss aborts.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int EXTRA_STAGES = 1,
  parameter int HOLD_CYCLES  = 16,
  parameter int STEP_CYCLES  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ready_a,
  input  logic                sw_reset,
  output logic [CHANNELS-1:0] sreset,
`ifdef RESET_SEQUENCER_ABORT_CNT_EN
  output logic                done,
  output logic [7:0]          abort_cnt
`else
  output logic                done
`endif
);

  localparam int RST_STAGES = 1 + EXTRA_STAGES;
  localparam int RDY_STAGES = 2 + EXTRA_STAGES;
  localparam int CW         = cnt_width(HOLD_CYCLES, STEP_CYCLES);
  localparam int IW         = (CHANNELS < 2) ? 1 : $clog2(CHANNELS + 1);

  localparam logic [CW-1:0]       HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]       STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0]       IDX_LAST  = IW'(CHANNELS - 1);
  localparam logic [CHANNELS-1:0] CH_ONE    = CHANNELS'(1);

  logic [RST_STAGES-1:0] rst_chain;
  logic                  rst_s;
  logic                  ready_s;
  logic                  abort;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;

  // Reset release synchronizer: presets on reset, zeros shift in after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_chain <= '1;
    end else begin
      rst_chain[0] <= 1'b0;
      for (int i = 1; i < RST_STAGES; i++) begin
        rst_chain[i] <= rst_chain[i-1];
      end
    end
  end

  assign rst_s = rst_chain[RST_STAGES-1];

  bit_synchronizer #(
    .STAGES (RDY_STAGES)
  ) u_ready_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ready_a),
    .q     (ready_s)
  );

  // Either request restarts a sequence in progress; both together are one abort.
  assign abort = sw_reset || !ready_s;

  // Sequencer FSM with registered channel resets, done flag and abort counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= HOLD;
      cnt    <= '0;
      idx    <= '0;
      sreset <= '1;
      done   <= 1'b0;
`ifdef RESET_SEQUENCER_ABORT_CNT_EN
      abort_cnt <= '0;
`endif
    end else if (rst_s) begin
      // Reset release not yet synchronized: park in HOLD without counting.
      state  <= HOLD;
      cnt    <= '0;
      idx    <= '0;
      sreset <= '1;
      done   <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          sreset <= '1;
          done   <= 1'b0;
          if (sw_reset) begin
            cnt <= '0;
          end else if (cnt == HOLD_LAST) begin
            state <= WAIT_READY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        WAIT_READY: begin
          sreset <= '1;
          done   <= 1'b0;
          if (sw_reset) begin
            state <= HOLD;
            cnt   <= '0;
          end else if (ready_s) begin
            state <= RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end
        end

        RELEASE: begin
          if (abort) begin
            state  <= HOLD;
            cnt    <= '0;
            idx    <= '0;
            sreset <= '1;
            done   <= 1'b0;
`ifdef RESET_SEQUENCER_ABORT_CNT_EN
            if (!ready_s && abort_cnt != ABORT_CNT_MAX) begin
              abort_cnt <= abort_cnt + 8'd1;
            end
`endif
          end else if (cnt == STEP_LAST) begin
            // Release the current channel; earlier channels stay released.
            sreset <= sreset & ~(CH_ONE << idx);
            cnt    <= '0;
            idx    <= idx + IW'(1);
            if (idx == IDX_LAST) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          if (abort) begin
            state  <= HOLD;
            cnt    <= '0;
            idx    <= '0;
            sreset <= '1;
            done   <= 1'b0;
`ifdef RESET_SEQUENCER_ABORT_CNT_EN
            if (!ready_s && abort_cnt != ABORT_CNT_MAX) begin
              abort_cnt <= abort_cnt + 8'd1;
            end
`endif
          end else begin
            sreset <= '0;
            done   <= 1'b1;
          end
        end

        default: begin
          state  <= HOLD;
          cnt    <= '0;
          idx    <= '0;
          sreset <= '1;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a 4-channel instance and a 1-channel, 1-cycle
// instance share stimulus; a behavioural reference tracks both.
module tb_reset_sequencer;

  localparam int RST_STAGES = 2;
  localparam int RDY_STAGES = 3;
  localparam int P_CH   [2] = '{4, 1};
  localparam int P_HOLD [2] = '{16, 1};
  localparam int P_STEP [2] = '{8, 1};

  // Clock / reset block
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ready_a = 1'b0;
  logic sw_reset = 1'b0;

  always #5 clk = ~clk;

  logic [3:0] sreset0;
  logic       done0;
  logic [0:0] sreset1;
  logic       done1;
`ifdef RESET_SEQUENCER_ABORT_CNT_EN
  logic [7:0] abort_cnt0;
  logic [7:0] abort_cnt1;
`endif

  reset_sequencer #(
    .CHANNELS(4), .EXTRA_STAGES(1), .HOLD_CYCLES(16), .STEP_CYCLES(8)
  ) dut0 (
    .clk       (clk),
    .reset     (reset),
    .ready_a   (ready_a),
    .sw_reset  (sw_reset),
    .sreset    (sreset0),
`ifdef RESET_SEQUENCER_ABORT_CNT_EN
    .abort_cnt (abort_cnt0),
`endif
    .done      (done0)
  );

  reset_sequencer #(
    .CHANNELS(1), .EXTRA_STAGES(1), .HOLD_CYCLES(1), .STEP_CYCLES(1)
  ) dut1 (
    .clk       (clk),
    .reset     (reset),
    .ready_a   (ready_a),
    .sw_reset  (sw_reset),
    .sreset    (sreset1),
`ifdef RESET_SEQUENCER_ABORT_CNT_EN
    .abort_cnt (abort_cnt1),
`endif
    .done      (done1)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: edges left in the hold, edges spent releasing (-1 = not
  // started), ready-loss abort count, edges since reset release, ready history.
  int hold_left [2];
  int rel       [2];
  int acnt      [2];
  int rst_cnt;
  bit rdy_q[$];

  function automatic int released(int i);
    if (rel[i] < 0) return 0;
    return rel[i] / P_STEP[i];
  endfunction

  function automatic logic [3:0] exp_sreset(int i);
    int all_mask;
    all_mask = (1 << P_CH[i]) - 1;
    return 4'(all_mask & ~((1 << released(i)) - 1));
  endfunction

  function automatic logic exp_done(int i);
    return released(i) == P_CH[i];
  endfunction

  task automatic model_clear();
    rst_cnt = 0;
    rdy_q = '{1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      hold_left[i] = P_HOLD[i];
      rel[i] = -1;
      acnt[i] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit rs;
    if (reset) begin
      model_clear();
      return;
    end
    rst_cnt++;
    rs = rdy_q[0];
    void'(rdy_q.pop_front());
    rdy_q.push_back(ready_a);
    for (int i = 0; i < 2; i++) begin
      if (rst_cnt <= RST_STAGES) begin
        hold_left[i] = P_HOLD[i];
        rel[i] = -1;
      end else if (rel[i] >= 0 && (sw_reset || !rs)) begin
        hold_left[i] = P_HOLD[i];
        rel[i] = -1;
        if (!rs && acnt[i] < 255) acnt[i]++;
      end else if (hold_left[i] > 0) begin
        hold_left[i] = sw_reset ? P_HOLD[i] : hold_left[i] - 1;
      end else if (rel[i] < 0) begin
        if (sw_reset) hold_left[i] = P_HOLD[i];
        else if (rs) rel[i] = 0;
      end else if (rel[i] < P_CH[i] * P_STEP[i]) begin
        rel[i]++;
      end
    end
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("sreset0", 32'(sreset0), 32'(exp_sreset(0)));
    check("done0", 32'(done0), 32'(exp_done(0)));
    check("sreset1", 32'(sreset1), 32'(exp_sreset(1)));
    check("done1", 32'(done1), 32'(exp_done(1)));
`ifdef RESET_SEQUENCER_ABORT_CNT_EN
    check("abort_cnt0", 32'(abort_cnt0), 32'(acnt[0]));
    check("abort_cnt1", 32'(abort_cnt1), 32'(acnt[1]));
`endif
  endtask

  // Driver: one clock edge, model update, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();

    // Power-on with ready already present.
    reset = 1'b1;
    ready_a = 1'b1;
    repeat (5) tick();
    check("t1_in_reset", 32'(sreset0), 32'hf);
    reset = 1'b0;
    repeat (RST_STAGES + 48) tick();
    check("t1_done_early", 32'(done0), 32'h0);
    tick();
    check("t1_done", 32'(done0), 32'h1);
    check("t1_sreset", 32'(sreset0), 32'h0);

    // Late ready: wait in WAIT_READY, then bit0 drops 3+1+8 edges after rise.
    reset = 1'b1;
    ready_a = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (100) tick();
    check("t2_waiting", 32'(sreset0), 32'hf);
    ready_a = 1'b1;
    repeat (RDY_STAGES + 1 + 8 - 1) tick();
    check("t2_bit0_held", 32'(sreset0[0]), 32'h1);
    tick();
    check("t2_bit0_drop", 32'(sreset0[0]), 32'h0);

    // Ready loss mid-release.
    for (int k = 0; k < 200 && rel[0] < 16; k++) tick();
    check("t3_1100", 32'(sreset0), 32'hc);
    ready_a = 1'b0;
    repeat (RDY_STAGES) tick();
    check("t3_not_yet", 32'(sreset0), 32'hc);
    tick();
    check("t3_abort_sreset", 32'(sreset0), 32'hf);
    check("t3_abort_done", 32'(done0), 32'h0);
    repeat ($urandom_range(20, 40)) tick();
    ready_a = 1'b1;
    for (int k = 0; k < 100 && !exp_done(0); k++) tick();
    check("t3_resequenced", 32'(done0), 32'h1);

    // Software re-sequence from DONE.
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    check("t4_abort_sreset", 32'(sreset0), 32'hf);
    check("t4_abort_done", 32'(done0), 32'h0);
    repeat (16 + 4 * 8) tick();
    check("t4_done_early", 32'(done0), 32'h0);
    tick();
    check("t4_done", 32'(done0), 32'h1);

    // Asynchronous reset between edges in the middle of a release.
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    for (int k = 0; k < 100 && rel[0] < 12; k++) tick();
    check("t5_pre", 32'(sreset0), 32'he);
    #2 reset = 1'b1;
    #1;
    model_clear();
    check("t5_async_sreset", 32'(sreset0), 32'hf);
    check("t5_async_done", 32'(done0), 32'h0);
    check("t5_async_sreset1", 32'(sreset1), 32'h1);
    repeat (3) tick();
    reset = 1'b0;
    repeat (60) tick();

    // Randomized ready toggling with occasional software requests.
    for (int n = 0; n < 400; n++) begin
      ready_a = 1'b1;
      repeat ($urandom_range(2, 6)) tick();
      ready_a = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        sw_reset = 1'b1;
        tick();
        sw_reset = 1'b0;
      end
      repeat ($urandom_range(2, 6)) tick();
    end
`ifdef RESET_SEQUENCER_ABORT_CNT_EN
    check("t6_abort_cnt_sat", 32'(abort_cnt1), 32'd255);
`endif
    ready_a = 1'b1;
    for (int k = 0; k < 100 && !exp_done(0); k++) tick();
    check("t6_final_done0", 32'(done0), 32'h1);
    check("t6_final_sreset1", 32'(sreset1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
